// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 types, round-count constant, round-constant
//                table and GF(2^8) multiply-by-2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    // Number of AES-128 rounds; the round index runs 0..NR
    localparam logic [3:0] NR = 4'd10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    // One registered output entry of the key-add stage
    typedef struct packed {
        block_t     state;
        logic [3:0] round;
        logic       last;
    } out_entry_t;

    // GF(2^8) multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant used when deriving round key idx+1 from round key idx
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Cyclic left rotation of a word by one byte
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box (8-bit in, 8-bit out).
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Entry 0 occupies the most significant byte of the table
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits at bit offset (255-n)*8, i.e. {~n, 3'b000}
    logic [10:0] w_bit_ofs;
    assign w_bit_ofs = {~byte_i, 3'b000};
    assign byte_o    = SBOX_TABLE[w_bit_ofs +: 8];

endmodule : aes_sbox
`default_nettype wire

// File: rtl/round_key_add.sv
`default_nettype none
// ============================================================================
//  Module      : round_key_add
//  Description : AES-128 AddRoundKey pipeline stage with an on-the-fly key
//                schedule advancing one round per accepted state. One
//                registered output entry, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module round_key_add
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_out,
    output logic         last_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    block_t     ck_q,  ck_d;
    block_t     rk_q,  rk_d;
    logic [3:0] rnd_q, rnd_d;
    out_entry_t out_q, out_d;
    logic       out_valid_q, out_valid_d;

    logic w_in_xfer;
    logic w_out_xfer;

    // ------------------------------------------------------------------
    // Handshake: a key load blocks input so a state is never keyed with
    // a schedule that is being replaced in the same cycle.
    // ------------------------------------------------------------------
    assign in_ready   = (!out_valid_q || out_ready) && !key_load;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Next round key from the current one
    // ------------------------------------------------------------------
    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_rot, w_sub, w_t;
    word_t w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = rk_q;
    assign w_rot = rot_word(w_w3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .byte_i (w_rot[8*gi +: 8]),
                .byte_o (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {rcon(rnd_q), 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    // Key schedule: reload on key_load, advance or wrap on each accepted state
    always_comb begin
        ck_d  = ck_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        if (key_load) begin
            ck_d  = key_in;
            rk_d  = key_in;
            rnd_d = 4'd0;
        end else if (w_in_xfer) begin
            if (rnd_q == NR) begin
                rk_d  = ck_q;
                rnd_d = 4'd0;
            end else begin
                rk_d  = {w_n0, w_n1, w_n2, w_n3};
                rnd_d = rnd_q + 4'd1;
            end
        end
    end

    // Output entry: capture keyed state on input, drop valid when drained
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (w_in_xfer) begin
            out_d.state = state_in ^ rk_q;
            out_d.round = rnd_q;
            out_d.last  = (rnd_q == NR);
            out_valid_d = 1'b1;
        end else if (w_out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Register all state; reset clears key material and the pending output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= 4'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ck_q        <= ck_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign state_out = out_q.state;
    assign round_out = out_q.round;
    assign last_out  = out_q.last;

endmodule : round_key_add
`default_nettype wire

// File: tb/tb_round_key_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_key_add
//  Description : Directed self-checking bench for round_key_add using the
//                FIPS-197 AES-128 key expansion example.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_round_key_add;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [3:0]   round_out;
    logic         last_out;

    int n_tests;
    int n_fail;

    logic [127:0] RK [0:10];
    logic [127:0] c_key;
    logic [127:0] c_key2;

    round_key_add dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .round_out (round_out),
        .last_out  (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        c_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        c_key2  = 128'h000102030405060708090a0b0c0d0e0f;
        RK[0]   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        RK[1]   = 128'ha0fafe1788542cb123a339392a6c7605;
        RK[2]   = 128'hf2c295f27a96b9435935807a7359f67f;
        RK[3]   = 128'h3d80477d4716fe3e1e237e446d7a883b;
        RK[4]   = 128'hef44a541a8525b7fb671253bdb0bad00;
        RK[5]   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        RK[6]   = 128'h6d88a37a110b3efddbf98641ca0093fd;
        RK[7]   = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        RK[8]   = 128'head27321b58dbad2312bf5607f8d292f;
        RK[9]   = 128'hac7766f319fadc2128d12941575c006e;
        RK[10]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst       = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        state_in  = '0;
        out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset state_out", state_out, 128'd0);
        chk("reset round_out", 128'(round_out), 128'd0);
        chk("reset last_out",  128'(last_out), 128'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 128'(in_ready), 128'd1);

        // Schedule from the all-zero key before any key_load
        in_valid  = 1'b1;
        state_in  = '0;
        out_ready = 1'b1;
        step();
        chk("zero-key r0 state", state_out, 128'd0);
        chk("zero-key r0 round", 128'(round_out), 128'd0);
        chk("zero-key r0 valid", 128'(out_valid), 128'd1);
        step();
        chk("zero-key r1 state", state_out, 128'h62636363626363636263636362636363);
        chk("zero-key r1 round", 128'(round_out), 128'd1);

        // key_load together with in_valid while output is stalled
        out_ready = 1'b0;
        key_load  = 1'b1;
        key_in    = c_key;
        #1;
        chk("key_load blocks in_ready", 128'(in_ready), 128'd0);
        step();
        chk("key_load keeps out_valid", 128'(out_valid), 128'd1);
        chk("key_load keeps state_out", state_out, 128'h62636363626363636263636362636363);
        chk("key_load keeps round_out", 128'(round_out), 128'd1);

        // FIPS-197 input block keyed at round 0 with the new key
        key_load  = 1'b0;
        out_ready = 1'b1;
        state_in  = 128'h3243f6a8885a308d313198a2e0370734;
        step();
        chk("fips block state", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("fips block round", 128'(round_out), 128'd0);
        chk("fips block last",  128'(last_out), 128'd0);

        // Zero states back-to-back expose round keys 1..10
        state_in = '0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("rk%0d state", i), state_out, RK[i]);
            chk($sformatf("rk%0d round", i), 128'(round_out), 128'(i));
            chk($sformatf("rk%0d last", i),  128'(last_out), 128'(i == 10));
            chk($sformatf("rk%0d valid", i), 128'(out_valid), 128'd1);
        end

        // Twelfth block wraps to the round-0 key
        step();
        chk("wrap state", state_out, RK[0]);
        chk("wrap round", 128'(round_out), 128'd0);
        chk("wrap last",  128'(last_out), 128'd0);

        // Backpressure for 5 cycles with input pending
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d in_ready", i), 128'(in_ready), 128'd0);
            step();
            chk($sformatf("stall%0d state", i), state_out, RK[0]);
            chk($sformatf("stall%0d round", i), 128'(round_out), 128'd0);
            chk($sformatf("stall%0d valid", i), 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        step();
        chk("post-stall state", state_out, RK[1]);
        chk("post-stall round", 128'(round_out), 128'd1);

        // Advance to round 5, then reset mid-operation
        for (int i = 2; i <= 5; i++) begin
            step();
            chk($sformatf("pre-rst rk%0d", i), state_out, RK[i]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("async rst out_valid", 128'(out_valid), 128'd0);
        chk("async rst state_out", state_out, 128'd0);
        chk("async rst round_out", 128'(round_out), 128'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst release in_ready", 128'(in_ready), 128'd1);

        // Reload a different key and key one zero block at round 0
        key_load = 1'b1;
        key_in   = c_key2;
        step();
        key_load  = 1'b0;
        in_valid  = 1'b1;
        state_in  = '0;
        out_ready = 1'b1;
        step();
        chk("reload state", state_out, c_key2);
        chk("reload round", 128'(round_out), 128'd0);
        chk("reload valid", 128'(out_valid), 128'd1);

        // Drain without new input clears out_valid
        in_valid = 1'b0;
        step();
        chk("drain valid", 128'(out_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_round_key_add
`default_nettype wire
